icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the program counter stage and the instruction memory bus.
- Accepts a fetch address with a valid flag from the PC stage and returns one 32-bit instruction with a one-cycle instr_valid pulse.
- On a miss, refills a whole line from memory, one word per beat, then completes the fetch.

Parameters:
- DATA_WIDTH, 32, address/instruction width.
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pc_addr  input  DATA_WIDTH  byte fetch address from the PC stage
- pc_valid  input  1  fetch request
- instr  output  DATA_WIDTH  fetched instruction; valid only while instr_valid=1
- instr_valid  output  1  one-cycle response pulse
- mem_req  output  1  refill word request
- mem_addr  output  DATA_WIDTH  word-aligned refill address
- mem_ready  input  1  memory returns mem_rdata this cycle; completes the current beat
- mem_rdata  input  DATA_WIDTH  refill data

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset:
  - state=IDLE, all valid bits=0, instr=0, instr_valid=0, mem_req=0, mem_addr=0, beat counter=0.
  - A reset during REFILL aborts it immediately, with no line validated and mem_req low asynchronously.
- Address split:
  - [1:0] ignored.
  - word = [2+WB-1:2], where WB=log2(WORDS_PER_LINE).
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage: per-line valid bit, tag register and WORDS_PER_LINE data words. Storage is only written during refill.
- IDLE:
  - When pc_valid=1 and instr_valid=0, latch pc_addr into req_addr and go to LOOKUP.
  - A request coinciding with instr_valid=1 is not accepted.
  - pc_valid=0: stay in IDLE.
- LOOKUP:
  - Compare valid[index] and tag against req_addr.
  - Hit: register instr=data[index][word], set instr_valid=1 for the next cycle only, go to IDLE.
  - Miss: clear valid[index], beat=0, go to REFILL.
- REFILL:
  - mem_req=1 and mem_addr={tag,index,beat,2'b00}.
  - When mem_ready=1, write mem_rdata to data[index][beat] and increment beat.
  - When mem_ready=1 on beat=WORDS_PER_LINE-1, set valid[index]=1, write the tag, drop mem_req on the next cycle, go to LOOKUP.
  - The LOOKUP that follows is a guaranteed hit.
  - mem_req holds continuously across beats. mem_addr changes only after an accepted beat.
- Latency:
  - Hit: instr_valid rises 2 cycles after the request-accept edge.
  - Miss: 2 + refill beats + 1 cycles, plus memory stall cycles.
- instr_valid is never high for two consecutive cycles.
- instr holds its last value when instr_valid=0.
- Changes on pc_addr after acceptance are ignored until the response is delivered.
- The beat counter wraps to 0 after the last beat.

Optional Feature:
- Macro: ICACHE_FLUSH_EN.
- With the macro: adds an input port flush (1 bit).
  - flush=1 in IDLE clears all valid bits on the next edge. A request in the same IDLE cycle is still accepted and sees the flushed (empty) cache.
  - flush=1 in LOOKUP or REFILL is latched as pending and applied on the first IDLE cycle. The in-flight fetch still completes with correct data.
- Without the macro: no flush port; valid bits are cleared only by reset.

Test Plan:
- Cold miss:
  - Stimulus: reset, then pc_valid=1, pc_addr=0x0000_0000; memory returns 0x11,0x22,0x33,0x44 with mem_ready=1 each cycle.
  - Response: mem_addr sequence 0x0,0x4,0x8,0xC; instr=0x11 with a single instr_valid pulse.
- Hit after refill:
  - Stimulus: next request pc_addr=0x8.
  - Response: no mem_req; instr=0x33, instr_valid 2 cycles after accept.
- Conflict eviction (LINES=16, WORDS=4):
  - Stimulus: fetch 0x100, which maps to the same index 0 as 0x0 with a different tag.
  - Response: refill at 0x100..0x10C. A later fetch of 0x0 misses again.
- Memory stall:
  - Stimulus: mem_ready low 3 cycles before each beat.
  - Response: mem_req stays 1 and mem_addr stable during each stall; correct word returned.
- Reset mid-refill:
  - Stimulus: rst_n low after beat 1 of the refill for 0x40.
  - Response: mem_req=0 immediately; re-fetch of 0x40 misses and refills fully.
- Flush (ICACHE_FLUSH_EN):
  - Stimulus: fill 0x0, pulse flush in IDLE, fetch 0x4.
  - Response: miss, with a full refill from 0x0.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: one-word fetches from the PC stage, whole-line refills on a miss.
// Optional: define ICACHE_FLUSH_EN to add a flush input that invalidates every line.
module icache_dm #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ICACHE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [DATA_WIDTH-1:0] pc_addr,
    input  logic                  pc_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TW = DATA_WIDTH - 2 - WB - IB;
    localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:2]   req_addr_q;
    logic [LINES-1:0]        valid_q;
    logic [TW-1:0]           tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES][WORDS_PER_LINE];
    logic [WB-1:0]           beat_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    instr_valid_q;
    logic                    mem_req_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q;
`ifdef ICACHE_FLUSH_EN
    logic                    flush_pend_q;
`endif

    logic [WB-1:0] req_word;
    logic [IB-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [WB-1:0] beat_nxt;
    logic          hit;
    logic          refill_we;
    logic          unused_lsbs;

    assign req_word    = req_addr_q[2+WB-1:2];
    assign req_idx     = req_addr_q[2+WB+IB-1:2+WB];
    assign req_tag     = req_addr_q[DATA_WIDTH-1:2+WB+IB];
    assign beat_nxt    = beat_q + WB'(1);
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign refill_we   = (state_q == REFILL) && mem_ready;
    assign unused_lsbs = ^pc_addr[1:0];

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_q[req_idx][beat_q] <= mem_rdata;
            if (beat_q == LAST_BEAT) begin
                tag_q[req_idx] <= req_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            valid_q       <= '0;
            beat_q        <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
`ifdef ICACHE_FLUSH_EN
            flush_pend_q  <= 1'b0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef ICACHE_FLUSH_EN
                    if (flush || flush_pend_q) begin
                        valid_q <= '0;
                    end
                    flush_pend_q <= 1'b0;
`endif
                    if (pc_valid && !instr_valid_q) begin
                        req_addr_q <= pc_addr[DATA_WIDTH-1:2];
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        instr_q       <= data_q[req_idx][req_word];
                        instr_valid_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        valid_q[req_idx] <= 1'b0;
                        beat_q           <= '0;
                        mem_req_q        <= 1'b1;
                        mem_addr_q       <= {req_tag, req_idx, {WB{1'b0}}, 2'b00};
                        state_q          <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        beat_q     <= beat_nxt;
                        mem_addr_q <= {req_tag, req_idx, beat_nxt, 2'b00};
                        if (beat_q == LAST_BEAT) begin
                            valid_q[req_idx] <= 1'b1;
                            mem_req_q        <= 1'b0;
                            state_q          <= LOOKUP;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef ICACHE_FLUSH_EN
            // A flush seen mid-fetch is deferred so the in-flight line stays coherent.
            if (flush && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm; the flush scenario runs only when ICACHE_FLUSH_EN is defined.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    int errors = 0;
    int checks = 0;

    // Results of the most recent fetch
    int          f_lat, f_pulses, f_beats, f_req_cycles;
    logic [31:0] f_instr;
    logic [31:0] f_addrs [8];
    logic        f_stall_ok, f_timeout;

    always #5 clk = ~clk;

    icache_dm #(.DATA_WIDTH(32), .LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef ICACHE_FLUSH_EN
        .flush       (flush),
`endif
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    // Backing memory: words 0x0..0xC hold 0x11,0x22,0x33,0x44; elsewhere 0xC0DE_xxxx with the low address half.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a < 32'h10) return ({30'b0, a[3:2]} + 32'd1) * 32'h11;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Issues one fetch and plays the memory side, recording what happened.
    task automatic fetch(input logic [31:0] a, input int stall);
        int cyc;
        int st;
        logic [31:0] held;
        f_lat = 0; f_pulses = 0; f_beats = 0; f_req_cycles = 0;
        f_instr = '0; f_stall_ok = 1'b1; f_timeout = 1'b0;
        st = 0; held = '0;
        for (int i = 0; i < 8; i++) f_addrs[i] = 32'hFFFF_FFFF;
        @(negedge clk);
        pc_addr = a; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0; pc_addr = 32'hDEAD_BEE0;
        cyc = 1;
        while (1) begin
            if (cyc > 300) begin f_timeout = 1'b1; break; end
            if (instr_valid) begin
                f_pulses++;
                f_instr = instr;
                if (f_lat == 0) f_lat = cyc;
            end
            if (mem_req) begin
                f_req_cycles++;
                if (st == 0) held = mem_addr;
                else if (mem_addr !== held) f_stall_ok = 1'b0;
                if (st < stall) begin
                    mem_ready = 1'b0; st++;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = memword(mem_addr);
                    if (f_beats < 8) f_addrs[f_beats] = mem_addr;
                    f_beats++;
                    st = 0;
                end
            end else begin
                mem_ready = 1'b0;
            end
            if (f_lat != 0 && cyc >= f_lat + 1) break;
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pc_valid = 1'b0; pc_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, 32'h0); end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss;
        fetch(32'h0000_0000, 0);
        checks++; if (f_timeout !== 1'b0) begin errors++; $display("FAIL cold_timeout: got %b expected 0", f_timeout); end
        checks++; if (f_beats != 4) begin errors++; $display("FAIL cold_beats: got %0d expected 4", f_beats); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f_addrs[i] !== 32'(i * 4)) begin errors++; $display("FAIL cold_addr%0d: got %h expected %h", i, f_addrs[i], 32'(i * 4)); end
        end
        checks++; if (f_instr !== 32'h11) begin errors++; $display("FAIL cold_instr: got %h expected %h", f_instr, 32'h11); end
        checks++; if (f_pulses != 1) begin errors++; $display("FAIL cold_pulses: got %0d expected 1", f_pulses); end
        checks++; if (f_lat != 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", f_lat); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cold_req_low: got %b expected 0", mem_req); end
        checks++; if (instr !== 32'h11) begin errors++; $display("FAIL cold_instr_hold: got %h expected %h", instr, 32'h11); end
    endtask

    task automatic test_hit;
        fetch(32'h0000_0008, 0);
        checks++; if (f_req_cycles != 0) begin errors++; $display("FAIL hit_no_req: got %0d expected 0", f_req_cycles); end
        checks++; if (f_instr !== 32'h33) begin errors++; $display("FAIL hit_instr: got %h expected %h", f_instr, 32'h33); end
        checks++; if (f_lat != 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", f_lat); end
        checks++; if (f_pulses != 1) begin errors++; $display("FAIL hit_pulses: got %0d expected 1", f_pulses); end
    endtask

    task automatic test_back_to_back;
        fetch(32'h0000_000C, 0);
        checks++; if (f_instr !== 32'h44) begin errors++; $display("FAIL b2b_instr_c: got %h expected %h", f_instr, 32'h44); end
        fetch(32'h0000_0004, 0);
        checks++; if (f_instr !== 32'h22) begin errors++; $display("FAIL b2b_instr_4: got %h expected %h", f_instr, 32'h22); end
        checks++; if (f_beats != 0) begin errors++; $display("FAIL b2b_beats: got %0d expected 0", f_beats); end
    endtask

    task automatic test_conflict;
        fetch(32'h0000_0100, 0);
        checks++; if (f_beats != 4) begin errors++; $display("FAIL conf_beats: got %0d expected 4", f_beats); end
        checks++; if (f_addrs[0] !== 32'h100) begin errors++; $display("FAIL conf_addr0: got %h expected %h", f_addrs[0], 32'h100); end
        checks++; if (f_addrs[3] !== 32'h10C) begin errors++; $display("FAIL conf_addr3: got %h expected %h", f_addrs[3], 32'h10C); end
        checks++; if (f_instr !== 32'hC0DE_0100) begin errors++; $display("FAIL conf_instr: got %h expected %h", f_instr, 32'hC0DE_0100); end
        fetch(32'h0000_0000, 0);
        checks++; if (f_beats != 4) begin errors++; $display("FAIL conf_remiss_beats: got %0d expected 4", f_beats); end
        checks++; if (f_addrs[0] !== 32'h0) begin errors++; $display("FAIL conf_remiss_addr0: got %h expected %h", f_addrs[0], 32'h0); end
        checks++; if (f_instr !== 32'h11) begin errors++; $display("FAIL conf_remiss_instr: got %h expected %h", f_instr, 32'h11); end
    endtask

    task automatic test_stall;
        fetch(32'h0000_02C8, 3);
        checks++; if (f_beats != 4) begin errors++; $display("FAIL stall_beats: got %0d expected 4", f_beats); end
        checks++; if (f_addrs[1] !== 32'h2C4) begin errors++; $display("FAIL stall_addr1: got %h expected %h", f_addrs[1], 32'h2C4); end
        checks++; if (f_stall_ok !== 1'b1) begin errors++; $display("FAIL stall_addr_stable: got %b expected 1", f_stall_ok); end
        checks++; if (f_req_cycles != 16) begin errors++; $display("FAIL stall_req_cycles: got %0d expected 16", f_req_cycles); end
        checks++; if (f_lat != 19) begin errors++; $display("FAIL stall_latency: got %0d expected 19", f_lat); end
        checks++; if (f_instr !== 32'hC0DE_02C8) begin errors++; $display("FAIL stall_instr: got %h expected %h", f_instr, 32'hC0DE_02C8); end
    endtask

    task automatic test_reset_mid_refill;
        @(negedge clk);
        pc_addr = 32'h40; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_high: got %b expected 1", mem_req); end
        for (int b = 0; b < 2; b++) begin
            mem_ready = 1'b1; mem_rdata = memword(mem_addr);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        checks++; if (mem_addr !== 32'h48) begin errors++; $display("FAIL mid_addr: got %h expected %h", mem_addr, 32'h48); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_async: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr_async: got %h expected %h", mem_addr, 32'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h40, 0);
        checks++; if (f_beats != 4) begin errors++; $display("FAIL mid_refetch_beats: got %0d expected 4", f_beats); end
        checks++; if (f_addrs[0] !== 32'h40) begin errors++; $display("FAIL mid_refetch_addr0: got %h expected %h", f_addrs[0], 32'h40); end
        checks++; if (f_addrs[3] !== 32'h4C) begin errors++; $display("FAIL mid_refetch_addr3: got %h expected %h", f_addrs[3], 32'h4C); end
        checks++; if (f_instr !== 32'hC0DE_0040) begin errors++; $display("FAIL mid_refetch_instr: got %h expected %h", f_instr, 32'hC0DE_0040); end
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush;
        fetch(32'h0, 0);
        fetch(32'h4, 0);
        checks++; if (f_beats != 0) begin errors++; $display("FAIL flush_prehit: got %0d expected 0", f_beats); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(32'h4, 0);
        checks++; if (f_beats != 4) begin errors++; $display("FAIL flush_beats: got %0d expected 4", f_beats); end
        checks++; if (f_addrs[0] !== 32'h0) begin errors++; $display("FAIL flush_addr0: got %h expected %h", f_addrs[0], 32'h0); end
        checks++; if (f_instr !== 32'h22) begin errors++; $display("FAIL flush_instr: got %h expected %h", f_instr, 32'h22); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_stall();
        test_reset_mid_refill();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
